dma_periph_fifo: RTL and testbench

AHB-Lite slave peripheral that buffers words from a streaming producer in a FIFO and exposes them to the DMA controller's master port as a read-only data register. It sits directly upstream of the DMAC. It raises a DMA request line when the buffered level reaches a programmable threshold, and drops it on the DMAC's request acknowledge. The DMAC reads this block as its transfer source.

---
 rtl/dma_periph_fifo_pkg.sv | 42 ++++
 rtl/dma_periph_fifo_sync_fifo.sv | 55 +++++
 rtl/dma_periph_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_dma_periph_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_periph_fifo_pkg.sv
// Shared definitions for the DMA peripheral FIFO: register offsets, AHB
// response/transfer encodings, state enums and the threshold clamp helper.
package dma_periph_pkg;

  // Register offsets, decoded from HAddr[3:2]
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // HResp encodings
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // HTrans encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // DMA request handshake states
  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_ASSERT,
    REQ_ACK
  } req_state_e;

  // Data-phase response: first (or only) cycle, or tail of a two-cycle ERROR
  typedef enum logic {
    RSP_FIRST,
    RSP_ERR_TAIL
  } rsp_state_e;

  // Threshold of 0 becomes 1; anything above the FIFO depth becomes the depth
  function automatic logic [7:0] clamp_thresh(input logic [7:0] val,
                                              input logic [7:0] max_lvl);
    if (val == 8'd0) return 8'd1;
    if (val > max_lvl) return max_lvl;
    return val;
  endfunction

endpackage

// File: rtl/dma_periph_fifo_sync_fifo.sv
// Synchronous single-clock FIFO with combinational head, full/empty flags and
// an occupancy counter one bit wider than the pointers. Bus-agnostic.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so not reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH; level tracks push/pop, unchanged on both
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dma_periph_fifo.sv
// AHB-Lite slave exposing a producer-fed FIFO as a read-only DATA register,
// with STATUS/CTRL registers and a DMA request handshake toward the DMAC.
// Optional feature macro DMA_PERIPH_WAIT_EN: an empty DATA read stalls with
// wait states until a word arrives instead of returning ERROR.
module dma_periph_fifo #(
  parameter int DEPTH  = 16,
  parameter int THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSel,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [31:0] HWData,
  input  logic        HReady,
  output logic [31:0] HRData,
  output logic        HReadyOut,
  output logic [1:0]  HResp,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        DmacReq,
  input  logic        ReqAck
);

  import dma_periph_pkg::*;

`ifdef DMA_PERIPH_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam int         LW       = $clog2(DEPTH) + 1;
  localparam logic [7:0] DEPTH_8  = DEPTH[7:0];
  localparam logic [7:0] THRESH_8 = THRESH[7:0];

  // FIFO interface
  logic [LW-1:0] level;
  logic [7:0]    lvl8;
  logic [31:0]   head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Address phase captured into the data phase
  logic          addr_hit;
  logic          vld_p1;
  logic          wr_p1;
  logic [1:0]    off_p1;
  rsp_state_e    rsp_state;

  // Control/status state
  logic          enable_q;
  logic          ovf_q;
  logic [7:0]    thresh_q;
  logic [31:0]   status_w;
  logic [31:0]   ctrl_w;

  // Data-phase decode results
  logic [31:0]   rdata_c;
  logic          ready_c;
  logic [1:0]    resp_c;
  logic          ctrl_wr;
  logic          err_start;

  // Request handshake
  req_state_e    req_state;
  logic          dmac_req_q;

  logic          unused_bits;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign push     = in_valid && !full;
  assign in_ready = !full;
  assign lvl8     = 8'(level);

  assign addr_hit = HSel && HReady &&
                    (HTrans != HTRANS_IDLE) && (HTrans != HTRANS_BUSY);

  assign status_w = {16'b0, lvl8, 5'b0, ovf_q, full, empty};
  assign ctrl_w   = {16'b0, thresh_q, 7'b0, enable_q};

  assign unused_bits = ^{HAddr[31:4], HAddr[1:0], HWData[30:16], HWData[7:1]};

  // Stage p0 -> p1: address phase registered into the data phase while the bus is ready
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      wr_p1  <= 1'b0;
      off_p1 <= OFF_DATA;
    end else if (HReady) begin
      vld_p1 <= addr_hit;
      wr_p1  <= HWrite;
      off_p1 <= HAddr[3:2];
    end
  end

  // Data-phase decode: read mux, pop, CTRL write strobe, ERROR start and stall
  always_comb begin
    rdata_c   = '0;
    ready_c   = 1'b1;
    resp_c    = RESP_OKAY;
    pop       = 1'b0;
    ctrl_wr   = 1'b0;
    err_start = 1'b0;
    if (rsp_state == RSP_ERR_TAIL) begin
      resp_c = RESP_ERROR;
    end else if (vld_p1) begin
      case (off_p1)
        OFF_DATA: begin
          if (wr_p1) begin
            err_start = 1'b1;
          end else if (!empty) begin
            rdata_c = head;
            pop     = 1'b1;
          end else if (WAIT_EN && enable_q) begin
            ready_c = 1'b0;
          end else begin
            err_start = 1'b1;
          end
        end
        OFF_STATUS: begin
          if (wr_p1) err_start = 1'b1;
          else       rdata_c   = status_w;
        end
        OFF_CTRL: begin
          if (wr_p1) ctrl_wr = 1'b1;
          else       rdata_c = ctrl_w;
        end
        default: rdata_c = '0;
      endcase
      if (err_start) begin
        ready_c = 1'b0;
        resp_c  = RESP_ERROR;
      end
    end
  end

  assign HRData    = rdata_c;
  assign HReadyOut = ready_c;
  assign HResp     = resp_c;

  // Stage p1 -> p2: an ERROR first cycle is always followed by its ready tail cycle
  always_ff @(posedge clk) begin
    if (rst) rsp_state <= RSP_FIRST;
    else     rsp_state <= err_start ? RSP_ERR_TAIL : RSP_FIRST;
  end

  // CTRL register and sticky overflow; a new overflow wins over a same-edge clear
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b0;
      thresh_q <= THRESH_8;
      ovf_q    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= HWData[0];
        thresh_q <= clamp_thresh(HWData[15:8], DEPTH_8);
        if (HWData[31]) ovf_q <= 1'b0;
      end
      if (in_valid && full) ovf_q <= 1'b1;
    end
  end

  // Request handshake FSM; DmacReq is registered and high only in REQ_ASSERT
  always_ff @(posedge clk) begin
    if (rst) begin
      req_state  <= REQ_IDLE;
      dmac_req_q <= 1'b0;
    end else if (!enable_q) begin
      req_state  <= REQ_IDLE;
      dmac_req_q <= 1'b0;
    end else begin
      case (req_state)
        REQ_IDLE: begin
          if (lvl8 >= thresh_q) begin
            req_state  <= REQ_ASSERT;
            dmac_req_q <= 1'b1;
          end
        end
        REQ_ASSERT: begin
          if (ReqAck) begin
            req_state  <= REQ_ACK;
            dmac_req_q <= 1'b0;
          end
        end
        REQ_ACK: begin
          if (!ReqAck) req_state <= REQ_IDLE;
        end
        default: begin
          req_state  <= REQ_IDLE;
          dmac_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign DmacReq = dmac_req_q;

endmodule

// File: tb/tb_dma_periph_fifo.sv
// Directed testbench for dma_periph_fifo (DEPTH=16, THRESH=4). The bus HReady
// is looped back from HReadyOut, modelling a single-slave AHB-Lite system.
module tb_dma_periph_fifo;

  logic        clk;
  logic        rst;
  logic        HSel;
  logic [31:0] HAddr;
  logic [1:0]  HTrans;
  logic        HWrite;
  logic [31:0] HWData;
  logic        HReady;
  logic [31:0] HRData;
  logic        HReadyOut;
  logic [1:0]  HResp;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        DmacReq;
  logic        ReqAck;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rd;
  logic        rdy;
  logic [1:0]  rsp;
  logic [31:0] br_data [16];
  logic        br_rdy  [16];
  logic [1:0]  br_resp [16];

  assign HReady = HReadyOut;

  dma_periph_fifo #(.DEPTH(16), .THRESH(4)) dut (
    .clk(clk), .rst(rst), .HSel(HSel), .HAddr(HAddr), .HTrans(HTrans),
    .HWrite(HWrite), .HWData(HWData), .HReady(HReady), .HRData(HRData),
    .HReadyOut(HReadyOut), .HResp(HResp), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .DmacReq(DmacReq), .ReqAck(ReqAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    HSel = 1'b0; HTrans = 2'b00; HWrite = 1'b0; HAddr = '0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
    HSel = 1'b1; HAddr = addr; HTrans = 2'b10; HWrite = 1'b1;
    tick();
    idle_bus();
    HWData = wdata;
    tick();
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic ok_rdy, output logic [1:0] resp);
    HSel = 1'b1; HAddr = addr; HTrans = 2'b10; HWrite = 1'b0;
    tick();
    idle_bus();
    data = HRData; ok_rdy = HReadyOut; resp = HResp;
    tick();
  endtask

  // Pipelined DATA reads: address of read i+1 overlaps data phase of read i
  task automatic burst_read(input int n);
    HSel = 1'b1; HAddr = 32'h0; HTrans = 2'b10; HWrite = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) idle_bus();
      br_data[i] = HRData; br_rdy[i] = HReadyOut; br_resp[i] = HResp;
      tick();
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (HRData !== 32'h0) begin n_bad++; $display("FAIL rst_hrdata: got %h want 0", HRData); end
    n_cmp++; if (HReadyOut !== 1'b1) begin n_bad++; $display("FAIL rst_hreadyout: got %b want 1", HReadyOut); end
    n_cmp++; if (HResp !== 2'b00) begin n_bad++; $display("FAIL rst_hresp: got %b want 00", HResp); end
    n_cmp++; if (DmacReq !== 1'b0) begin n_bad++; $display("FAIL rst_dmacreq: got %b want 0", DmacReq); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    bus_read(32'h4, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL rst_status: got %h want 00000001", rd); end
    bus_read(32'h8, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0400) begin n_bad++; $display("FAIL rst_ctrl: got %h want 00000400", rd); end
  endtask

  task automatic test_thresh_clamp();
    bus_write(32'h8, 32'h0000_0001);
    bus_read(32'h8, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0101) begin n_bad++; $display("FAIL thr_zero: got %h want 00000101", rd); end
    bus_write(32'h8, 32'h0000_1100);
    bus_read(32'h8, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_1000) begin n_bad++; $display("FAIL thr_over: got %h want 00001000", rd); end
    bus_write(32'h8, 32'h0000_0A00);
    bus_read(32'h8, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0A00) begin n_bad++; $display("FAIL thr_mid: got %h want 00000a00", rd); end
  endtask

  task automatic test_fill_request();
    bus_write(32'h8, 32'h0000_0401);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'hA0 + i;
      tick();
      n_cmp++; if (DmacReq !== 1'b0) begin n_bad++; $display("FAIL req_early[%0d]: got %b want 0", i, DmacReq); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (DmacReq !== 1'b1) begin n_bad++; $display("FAIL req_rise: got %b want 1", DmacReq); end
    ReqAck = 1'b1;
    tick();
    n_cmp++; if (DmacReq !== 1'b0) begin n_bad++; $display("FAIL req_ack_fall: got %b want 0", DmacReq); end
    ReqAck = 1'b0;
    tick();
    n_cmp++; if (DmacReq !== 1'b0) begin n_bad++; $display("FAIL req_ack_low: got %b want 0", DmacReq); end
    tick();
    n_cmp++; if (DmacReq !== 1'b1) begin n_bad++; $display("FAIL req_rearm: got %b want 1", DmacReq); end
  endtask

  task automatic test_burst_drain();
    burst_read(4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (br_data[i] !== 32'hA0 + i) begin n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, br_data[i], 32'hA0 + i); end
      n_cmp++; if (br_rdy[i] !== 1'b1 || br_resp[i] !== 2'b00) begin n_bad++; $display("FAIL drain_resp[%0d]: got rdy %b resp %b want 1/00", i, br_rdy[i], br_resp[i]); end
    end
    bus_read(32'h4, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL drain_status: got %h want 00000001", rd); end
  endtask

  task automatic test_illegal();
    push_word(32'h11);
    HSel = 1'b1; HAddr = 32'h0; HTrans = 2'b10; HWrite = 1'b1;
    tick();
    idle_bus(); HWData = 32'hDEAD_BEEF;
    n_cmp++; if (HReadyOut !== 1'b0 || HResp !== 2'b01) begin n_bad++; $display("FAIL wr_data_err1: got %b/%b want 0/01", HReadyOut, HResp); end
    tick();
    n_cmp++; if (HReadyOut !== 1'b1 || HResp !== 2'b01) begin n_bad++; $display("FAIL wr_data_err2: got %b/%b want 1/01", HReadyOut, HResp); end
    tick();
    n_cmp++; if (HReadyOut !== 1'b1 || HResp !== 2'b00) begin n_bad++; $display("FAIL wr_data_after: got %b/%b want 1/00", HReadyOut, HResp); end
    bus_read(32'h4, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0100) begin n_bad++; $display("FAIL wr_data_level: got %h want 00000100", rd); end
    bus_read(32'h0, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h11 || rdy !== 1'b1 || rsp !== 2'b00) begin n_bad++; $display("FAIL single_read: got %h %b %b want 00000011 1 00", rd, rdy, rsp); end
`ifndef DMA_PERIPH_WAIT_EN
    HSel = 1'b1; HAddr = 32'h0; HTrans = 2'b10; HWrite = 1'b0;
    tick();
    idle_bus();
    n_cmp++; if (HReadyOut !== 1'b0 || HResp !== 2'b01) begin n_bad++; $display("FAIL empty_rd_err1: got %b/%b want 0/01", HReadyOut, HResp); end
    tick();
    n_cmp++; if (HReadyOut !== 1'b1 || HResp !== 2'b01) begin n_bad++; $display("FAIL empty_rd_err2: got %b/%b want 1/01", HReadyOut, HResp); end
    tick();
`endif
    bus_read(32'h4, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL illegal_status: got %h want 00000001", rd); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + i;
      tick();
      n_cmp++; if (in_ready !== (i < 15)) begin n_bad++; $display("FAIL in_ready[%0d]: got %b want %b", i, in_ready, (i < 15)); end
    end
    in_valid = 1'b0;
    bus_read(32'h4, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_1006) begin n_bad++; $display("FAIL full_status: got %h want 00001006", rd); end
    bus_write(32'h8, 32'h8000_0401);
    bus_read(32'h4, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_1002) begin n_bad++; $display("FAIL ovf_clear: got %h want 00001002", rd); end
    burst_read(16);
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (br_data[i] !== 32'h100 + i) begin n_bad++; $display("FAIL full_drain[%0d]: got %h want %h", i, br_data[i], 32'h100 + i); end
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_simul_push_pop();
    for (int i = 0; i < 3; i++) push_word(32'hC0 + i);
    HSel = 1'b1; HAddr = 32'h0; HTrans = 2'b10; HWrite = 1'b0;
    tick();
    idle_bus(); in_valid = 1'b1; in_data = 32'hC3;
    n_cmp++; if (HRData !== 32'hC0) begin n_bad++; $display("FAIL simul_head: got %h want 000000c0", HRData); end
    tick();
    in_valid = 1'b0;
    bus_read(32'h4, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0300) begin n_bad++; $display("FAIL simul_level: got %h want 00000300", rd); end
    burst_read(3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (br_data[i] !== 32'hC1 + i) begin n_bad++; $display("FAIL simul_order[%0d]: got %h want %h", i, br_data[i], 32'hC1 + i); end
    end
  endtask

  task automatic test_wrap();
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 8; k++) push_word(32'hD000 + b * 8 + k);
      burst_read(8);
      for (int k = 0; k < 8; k++) begin
        n_cmp++; if (br_data[k] !== 32'hD000 + b * 8 + k) begin n_bad++; $display("FAIL wrap[%0d]: got %h want %h", b * 8 + k, br_data[k], 32'hD000 + b * 8 + k); end
      end
    end
    bus_read(32'h4, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL wrap_status: got %h want 00000001", rd); end
  endtask

`ifdef DMA_PERIPH_WAIT_EN
  task automatic test_wait_mode();
    HSel = 1'b1; HAddr = 32'h0; HTrans = 2'b10; HWrite = 1'b0;
    tick();
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin in_valid = 1'b1; in_data = 32'h55; end
      n_cmp++; if (HReadyOut !== 1'b0 || HResp !== 2'b00) begin n_bad++; $display("FAIL wait_cycle[%0d]: got %b/%b want 0/00", i, HReadyOut, HResp); end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (HReadyOut !== 1'b1 || HResp !== 2'b00 || HRData !== 32'h55) begin n_bad++; $display("FAIL wait_done: got %b/%b/%h want 1/00/00000055", HReadyOut, HResp, HRData); end
    tick();
    bus_read(32'h4, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL wait_status: got %h want 00000001", rd); end
  endtask
`endif

  task automatic test_reset_midway();
    push_word(32'h77);
    HSel = 1'b1; HAddr = 32'h4; HTrans = 2'b10; HWrite = 1'b1;
    tick();
    idle_bus(); HWData = 32'h0;
    n_cmp++; if (HReadyOut !== 1'b0 || HResp !== 2'b01) begin n_bad++; $display("FAIL wr_status_err1: got %b/%b want 0/01", HReadyOut, HResp); end
    rst = 1'b1;
    tick();
    n_cmp++; if (HReadyOut !== 1'b1 || HResp !== 2'b00) begin n_bad++; $display("FAIL midrst_resp: got %b/%b want 1/00", HReadyOut, HResp); end
    n_cmp++; if (HRData !== 32'h0 || DmacReq !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_outs: got %h/%b/%b want 0/0/1", HRData, DmacReq, in_ready); end
    rst = 1'b0;
    bus_read(32'h8, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0400) begin n_bad++; $display("FAIL midrst_ctrl: got %h want 00000400", rd); end
    bus_read(32'h4, rd, rdy, rsp);
    n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL midrst_status: got %h want 00000001", rd); end
  endtask

  initial begin
    rst = 1'b1; HSel = 1'b0; HAddr = '0; HTrans = 2'b00; HWrite = 1'b0;
    HWData = '0; in_valid = 1'b0; in_data = '0; ReqAck = 1'b0;
    test_reset();
    test_thresh_clamp();
    test_fill_request();
    test_burst_drain();
    test_illegal();
    test_full_overflow();
    test_simul_push_pop();
    test_wrap();
`ifdef DMA_PERIPH_WAIT_EN
    test_wait_mode();
`endif
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
